ex_wb: RTL and testbench



---
 rtl/ex_wb.sv | 76 +++++++
 tb/tb_ex_wb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb.sv
// Execute stage and EX/WB pipeline register. Computes the one-hot-selected ALU
// result and can feed the previous result back to either operand.
module ex_wb #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       rd_addr_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic             writeback_en_in,
    input  logic             alu_rs2_reg_in,
    input  logic             rs1_alu_loopback_in,
    input  logic             rs2_alu_loopback_in,
    input  logic             add_en_in,
    input  logic             sub_en_in,
    input  logic             xor_en_in,
    input  logic             or_en_in,
    input  logic             and_en_in,
    output logic [4:0]       rd_addr_out,
    output logic [XLEN-1:0]  result_out,
    output logic             writeback_en_out,
    output logic [CNT_W-1:0] retired_cnt
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] rs2_path;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            wb_commit;

    // Loopback taps the registered result, so a dependent instruction on the
    // very next cycle needs no bubble.
    assign op_a     = rs1_alu_loopback_in ? result_out : rs1_in;
    assign rs2_path = rs2_alu_loopback_in ? result_out : rs2_in;
    assign op_b     = alu_rs2_reg_in ? rs2_path : imm_in;

    always_comb begin
        // NOTE: default assigned first, so every path drives alu_result (no latch)
        // and the all-enables-low case yields 0.
        alu_result = '0;
        if (add_en_in)      alu_result = op_a + op_b;
        else if (sub_en_in) alu_result = op_a - op_b;
        else if (xor_en_in) alu_result = op_a ^ op_b;
        else if (or_en_in)  alu_result = op_a | op_b;
        else if (and_en_in) alu_result = op_a & op_b;
    end

    // Writes to x0 are dropped here so the register file never sees them.
    assign wb_commit = writeback_en_in && (rd_addr_in != 5'd0);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge
        // values, which is what lets loopback read the previous result.
        if (rst) begin
            rd_addr_out      <= '0;
            result_out       <= '0;
            writeback_en_out <= 1'b0;
            retired_cnt      <= '0;
        end else if (flush) begin
            rd_addr_out      <= '0;
            result_out       <= '0;
            writeback_en_out <= 1'b0;
        end else if (!stall) begin
            rd_addr_out      <= rd_addr_in;
            result_out       <= alu_result;
            writeback_en_out <= wb_commit;
            if (wb_commit) retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_wb.sv
// Self-checking bench for ex_wb: directed vector table, then random stimulus
// against an operation-level reference model.
module tb_ex_wb;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [4:0] OP_ADD = 5'b10000;
    localparam logic [4:0] OP_SUB = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b00001;
    localparam logic [4:0] OP_NONE = 5'b00000;

    typedef struct {
        logic             rst;
        logic             flush;
        logic             stall;
        logic [4:0]       op;      // {add, sub, xor, or, and}
        logic [4:0]       rd;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  imm;
        logic             wb;
        logic             rs2_sel;
        logic             lb1;
        logic             lb2;
        logic [4:0]       exp_rd;
        logic [XLEN-1:0]  exp_res;
        logic             exp_wb;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst, stall, flush;
    logic [4:0]       rd_addr_in;
    logic [XLEN-1:0]  rs1_in, rs2_in, imm_in;
    logic             writeback_en_in, alu_rs2_reg_in;
    logic             rs1_alu_loopback_in, rs2_alu_loopback_in;
    logic             add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in;
    logic [4:0]       rd_addr_out;
    logic [XLEN-1:0]  result_out;
    logic             writeback_en_out;
    logic [CNT_W-1:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_wb #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .flush               (flush),
        .rd_addr_in          (rd_addr_in),
        .rs1_in              (rs1_in),
        .rs2_in              (rs2_in),
        .imm_in              (imm_in),
        .writeback_en_in     (writeback_en_in),
        .alu_rs2_reg_in      (alu_rs2_reg_in),
        .rs1_alu_loopback_in (rs1_alu_loopback_in),
        .rs2_alu_loopback_in (rs2_alu_loopback_in),
        .add_en_in           (add_en_in),
        .sub_en_in           (sub_en_in),
        .xor_en_in           (xor_en_in),
        .or_en_in            (or_en_in),
        .and_en_in           (and_en_in),
        .rd_addr_out         (rd_addr_out),
        .result_out          (result_out),
        .writeback_en_out    (writeback_en_out),
        .retired_cnt         (retired_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic s,
                                input logic [4:0] op, input logic [4:0] rd,
                                input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                input logic [XLEN-1:0] imm, input logic wb,
                                input logic rs2_sel, input logic lb1, input logic lb2,
                                input logic [4:0] e_rd, input logic [XLEN-1:0] e_res,
                                input logic e_wb, input logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.op = op; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.wb = wb;
        v.rs2_sel = rs2_sel; v.lb1 = lb1; v.lb2 = lb2;
        v.exp_rd = e_rd; v.exp_res = e_res; v.exp_wb = e_wb; v.exp_cnt = e_cnt;
        return v;
    endfunction

    // Drive away from the edge, clock once, then sample 1 ns after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        rst = v.rst; flush = v.flush; stall = v.stall;
        {add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in} = v.op;
        rd_addr_in = v.rd; rs1_in = v.rs1; rs2_in = v.rs2; imm_in = v.imm;
        writeback_en_in = v.wb; alu_rs2_reg_in = v.rs2_sel;
        rs1_alu_loopback_in = v.lb1; rs2_alu_loopback_in = v.lb2;
        @(posedge clk);
        #1;
        check({tag, " rd_addr_out"}, 64'(rd_addr_out), 64'(v.exp_rd));
        check({tag, " result_out"}, 64'(result_out), 64'(v.exp_res));
        check({tag, " writeback_en_out"}, 64'(writeback_en_out), 64'(v.exp_wb));
        check({tag, " retired_cnt"}, 64'(retired_cnt), 64'(v.exp_cnt));
    endtask

    vec_t vecs[22];

    // Reference state: what the EX/WB register should hold after each edge.
    logic [4:0]       m_rd;
    logic [XLEN-1:0]  m_res;
    logic             m_wb;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [XLEN-1:0] pick_word();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return XLEN'(1);
            default: return XLEN'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        rd_addr_in = '0; rs1_in = '0; rs2_in = '0; imm_in = '0;
        writeback_en_in = 1'b0; alu_rs2_reg_in = 1'b0;
        rs1_alu_loopback_in = 1'b0; rs2_alu_loopback_in = 1'b0;
        {add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in} = '0;

        //            rst f  s  op       rd  rs1          rs2          imm        wb sel lb1 lb2  e_rd e_res         e_wb e_cnt
        vecs[0]  = mk(1, 0, 0, OP_NONE, 0,  0,           0,           0,         0, 0, 0, 0,   0,  0,            0, 0);
        vecs[1]  = mk(0, 0, 0, OP_ADD,  3,  5,           0,           7,         1, 0, 0, 0,   3,  12,           1, 1);
        vecs[2]  = mk(0, 0, 0, OP_ADD,  4,  1,           0,           1,         1, 0, 0, 0,   4,  2,            1, 2);
        vecs[3]  = mk(0, 0, 0, OP_ADD,  4,  32'hAAAA,    0,           1,         1, 0, 1, 0,   4,  3,            1, 3);
        vecs[4]  = mk(0, 0, 0, OP_ADD,  4,  32'hBBBB,    0,           1,         1, 0, 1, 0,   4,  4,            1, 4);
        vecs[5]  = mk(0, 0, 0, OP_SUB,  5,  0,           1,           0,         1, 1, 0, 0,   5,  32'hFFFFFFFF, 1, 5);
        vecs[6]  = mk(0, 0, 0, OP_ADD,  6,  32'hFFFFFFFF,0,           1,         1, 0, 0, 0,   6,  0,            1, 6);
        vecs[7]  = mk(0, 0, 0, OP_XOR,  0,  32'hF0,      32'hFF,      0,         1, 1, 0, 0,   0,  32'h0F,       0, 6);
        vecs[8]  = mk(0, 0, 1, OP_ADD,  7,  100,         0,           1,         1, 0, 0, 0,   0,  32'h0F,       0, 6);
        vecs[9]  = mk(0, 0, 1, OP_SUB,  8,  55,          3,           0,         1, 1, 1, 0,   0,  32'h0F,       0, 6);
        vecs[10] = mk(0, 0, 1, OP_OR,   9,  32'h1234,    0,           32'h10,    1, 0, 0, 0,   0,  32'h0F,       0, 6);
        vecs[11] = mk(0, 1, 1, OP_ADD,  7,  100,         0,           1,         1, 0, 0, 0,   0,  0,            0, 6);
        vecs[12] = mk(0, 0, 0, OP_ADD,  8,  2,           0,           3,         1, 0, 0, 0,   8,  5,            1, 7);
        vecs[13] = mk(0, 0, 0, OP_ADD,  8,  0,           0,           1,         1, 0, 1, 0,   8,  6,            1, 8);
        vecs[14] = mk(1, 1, 1, OP_ADD,  8,  0,           0,           1,         1, 0, 1, 0,   0,  0,            0, 0);
        vecs[15] = mk(0, 0, 0, OP_ADD,  9,  32'h5555,    0,           9,         1, 0, 1, 0,   9,  9,            1, 1);
        vecs[16] = mk(0, 0, 0, OP_OR,   10, 32'h100,     32'hDEAD,    32'h77,    0, 1, 0, 1,   10, 32'h109,      0, 1);
        vecs[17] = mk(0, 0, 0, OP_SUB | OP_XOR | OP_AND,
                               11, 10,          3,           0,         1, 1, 0, 0,   11, 7,            1, 2);
        vecs[18] = mk(0, 0, 0, OP_NONE, 12, 5,           6,           7,         1, 1, 0, 0,   12, 0,            1, 3);
        vecs[19] = mk(0, 0, 0, OP_AND,  1,  32'hF0F0,    0,           32'h0FF0,  1, 0, 0, 0,   1,  32'h00F0,     1, 4);
        vecs[20] = mk(0, 0, 0, OP_SUB,  2,  32'h1,       32'h2,       0,         1, 1, 1, 1,   2,  0,            1, 5);
        vecs[21] = mk(0, 1, 0, OP_ADD,  3,  4,           4,           4,         1, 1, 0, 0,   0,  0,            0, 5);

        for (int i = 0; i < 22; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Random phase: model works per instruction from the operand/priority
        // rules; a 4-bit counter ensures wrap-around is exercised.
        m_rd = '0; m_res = '0; m_wb = 1'b0; m_cnt = '0;
        for (int i = 0; i < 600; i++) begin
            vec_t v;
            logic [XLEN-1:0] a, b, r;
            v.rst     = (i == 0) || ($urandom_range(0, 63) == 0);
            v.flush   = ($urandom_range(0, 9) == 0);
            v.stall   = ($urandom_range(0, 7) == 0);
            v.op      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : (5'b1 << $urandom_range(0, 4));
            v.rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            v.rs1     = pick_word();
            v.rs2     = pick_word();
            v.imm     = pick_word();
            v.wb      = ($urandom_range(0, 3) != 0);
            v.rs2_sel = 1'($urandom);
            v.lb1     = 1'($urandom);
            v.lb2     = 1'($urandom);

            if (v.rst) begin
                m_rd = '0; m_res = '0; m_wb = 1'b0; m_cnt = '0;
            end else if (v.flush) begin
                m_rd = '0; m_res = '0; m_wb = 1'b0;
            end else if (!v.stall) begin
                a = v.lb1 ? m_res : v.rs1;
                b = v.rs2_sel ? (v.lb2 ? m_res : v.rs2) : v.imm;
                if (v.op[4])      r = a + b;
                else if (v.op[3]) r = a - b;
                else if (v.op[2]) r = a ^ b;
                else if (v.op[1]) r = a | b;
                else if (v.op[0]) r = a & b;
                else              r = '0;
                m_res = r;
                m_rd  = v.rd;
                m_wb  = v.wb && (v.rd != 5'd0);
                if (m_wb) m_cnt = m_cnt + 1'b1;
            end
            v.exp_rd = m_rd; v.exp_res = m_res; v.exp_wb = m_wb; v.exp_cnt = m_cnt;
            run_vec(v, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
